fetch: RTL and testbench

Instruction fetch stage of the SM83 core: owns the fetch PC, drives byte reads on the memory bus, and buffers fetched bytes in a 2-entry queue tagged with their address. It presents one opcode byte at a time to `decode` together with the CB-prefix flag (`o_is_instr16`, which drives decode's `i_is_instr16`). It also accepts PC redirects from control and halt requests.

---
 rtl/sm83_pkg.sv | 20 ++
 rtl/fetch_if.sv | 31 +++
 rtl/fetch_buf.sv | 69 ++++++
 rtl/fetch.sv | 112 +++++++++++
 tb/tb_fetch.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sm83_pkg.sv
// Shared SM83 core types and constants used by the fetch stage and its benches.
package sm83_pkg;

   typedef logic [7:0] instr_t;

   // Opcode that prefixes the extended (two-byte) instruction page.
   localparam instr_t OP_INSTR_16 = 8'hCB;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      DRAIN
   } fetch_state_t;

   typedef struct packed {
      logic [15:0] pc;
      instr_t      data;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_if.sv
// Memory read bus and instruction byte stream between fetch and its neighbours.
interface fetch_if;
   import sm83_pkg::*;

   logic        mem_req;
   logic [15:0] mem_addr;
   logic        mem_ack;
   logic [7:0]  mem_rdata;

   logic        ir_valid;
   logic        ir_ready;
   instr_t      instr;
   logic [15:0] instr_pc;
   logic        o_is_instr16;
   logic        i_cb_prefix;

   modport master (
      output mem_req, mem_addr,
      input  mem_ack, mem_rdata,
      output ir_valid, instr, instr_pc, o_is_instr16,
      input  ir_ready, i_cb_prefix
   );

   modport slave (
      input  mem_req, mem_addr,
      output mem_ack, mem_rdata,
      input  ir_valid, instr, instr_pc, o_is_instr16,
      output ir_ready, i_cb_prefix
   );

endinterface

// File: rtl/fetch_buf.sv
// Two-entry FIFO of fetched bytes tagged with their address; flush wins over push/pop.
module fetch_buf
   import sm83_pkg::*;
#(
   parameter fetch_entry_t RESET_ENTRY = '0
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  fetch_entry_t push_entry,
   input  logic         pop,
   input  logic         flush,
   output logic [1:0]   count,
   output fetch_entry_t head
);

   fetch_entry_t mem_q [2];
   fetch_entry_t mem_d [2];
   logic         wr_ptr_q, wr_ptr_d;
   logic         rd_ptr_q, rd_ptr_d;
   logic [1:0]   count_q, count_d;
   logic         push_ok, pop_ok;

   assign pop_ok  = pop && (count_q != 2'd0);
   assign push_ok = push && ((count_q != 2'd2) || pop_ok);

   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = 1'b0;
         rd_ptr_d = 1'b0;
         count_d  = 2'd0;
      end else begin
         if (push_ok) begin
            mem_d[wr_ptr_q] = push_entry;
            wr_ptr_d        = ~wr_ptr_q;
         end
         if (pop_ok) begin
            rd_ptr_d = ~rd_ptr_q;
         end
         count_d = count_q + {1'b0, push_ok} - {1'b0, pop_ok};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: storage is reset too (only two entries) so the head shows a defined value out of reset.
         mem_q[0] <= RESET_ENTRY;
         mem_q[1] <= RESET_ENTRY;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         // NOTE: sequential state uses <= so every flop samples pre-edge values.
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign count = count_q;
   assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch.sv
// SM83 instruction fetch: PC owner, single-outstanding byte reads, 2-entry tagged byte queue.
module fetch
   import sm83_pkg::*;
#(
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        redir_valid,
   input  logic [15:0] redir_pc,
   input  logic        i_halt,
   fetch_if.master     bus
);

   localparam fetch_entry_t RESET_ENTRY = '{pc: RESET_PC, data: 8'h00};

   fetch_state_t state_q, state_d;
   logic [15:0]  fetch_pc_q, fetch_pc_d;
   logic [15:0]  drain_addr_q, drain_addr_d;
   logic         cb_q, cb_d;

   logic [1:0]   buf_count;
   logic [1:0]   cnt_after;
   fetch_entry_t head;
   fetch_entry_t push_entry;
   logic         push, pop;

   // A redirect discards both the returning byte and any consume in the same cycle.
   assign pop        = bus.ir_valid && bus.ir_ready && !redir_valid;
   assign push       = (state_q == REQ) && bus.mem_ack && !redir_valid;
   assign push_entry = '{pc: fetch_pc_q, data: bus.mem_rdata};
   assign cnt_after  = buf_count + {1'b0, push} - {1'b0, pop};

   fetch_buf #(
      .RESET_ENTRY(RESET_ENTRY)
   ) u_buf (
      .clk        (clk),
      .rst_n      (rst_n),
      .push       (push),
      .push_entry (push_entry),
      .pop        (pop),
      .flush      (redir_valid),
      .count      (buf_count),
      .head       (head)
   );

   always_comb begin
      state_d      = state_q;
      fetch_pc_d   = fetch_pc_q;
      drain_addr_d = drain_addr_q;
      cb_d         = cb_q;

      if (pop) begin
         cb_d = bus.i_cb_prefix && !cb_q;
      end
      if (redir_valid) begin
         cb_d       = 1'b0;
         fetch_pc_d = redir_pc;
      end

      unique case (state_q)
         IDLE: begin
            if (!i_halt && (redir_valid || buf_count != 2'd2)) begin
               state_d = REQ;
            end
         end
         REQ: begin
            if (redir_valid) begin
               if (bus.mem_ack) begin
                  state_d = i_halt ? IDLE : REQ;
               end else begin
                  // Bus address must hold until the orphaned read completes.
                  state_d      = DRAIN;
                  drain_addr_d = fetch_pc_q;
               end
            end else if (bus.mem_ack) begin
               fetch_pc_d = fetch_pc_q + 16'd1;
               state_d    = (!i_halt && cnt_after != 2'd2) ? REQ : IDLE;
            end
         end
         DRAIN: begin
            // Queue is empty here: it was flushed on entry and drained data is dropped.
            if (bus.mem_ack) begin
               state_d = i_halt ? IDLE : REQ;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         fetch_pc_q   <= RESET_PC;
         drain_addr_q <= RESET_PC;
         cb_q         <= 1'b0;
      end else begin
         state_q      <= state_d;
         fetch_pc_q   <= fetch_pc_d;
         drain_addr_q <= drain_addr_d;
         cb_q         <= cb_d;
      end
   end

   assign bus.mem_req      = (state_q != IDLE);
   assign bus.mem_addr     = (state_q == DRAIN) ? drain_addr_q : fetch_pc_q;
   assign bus.ir_valid     = (buf_count != 2'd0);
   assign bus.instr        = head.data;
   assign bus.instr_pc     = head.pc;
   assign bus.o_is_instr16 = cb_q;

endmodule

// File: tb/tb_fetch.sv
// Directed bench for fetch: table-driven streaming check plus hand-written redirect/halt/wrap sequences.
module tb_fetch;
   import sm83_pkg::*;

   typedef struct {
      logic [15:0] pc;
      instr_t      data;
      logic        exp_cb;
   } vec_t;

   typedef struct {
      instr_t      data;
      logic [15:0] pc;
      logic        cb;
      int          cyc;
   } cons_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        redir_valid = 1'b0;
   logic [15:0] redir_pc = 16'h0000;
   logic        i_halt = 1'b0;
   logic        ir_ready = 1'b0;
   logic        mem_ack_r = 1'b0;
   logic [7:0]  mem_rdata_r = 8'h00;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int wait_states = 0;
   int wcnt = 0;

   logic [7:0]  mem [0:65535];
   logic [15:0] acklog[$];
   cons_t       conslog[$];
   vec_t        tbl[7];

   fetch_if bus();

   assign bus.mem_ack     = mem_ack_r;
   assign bus.mem_rdata   = mem_rdata_r;
   assign bus.ir_ready    = ir_ready;
   assign bus.i_cb_prefix = (bus.instr == OP_INSTR_16);

   fetch #(
      .RESET_PC(16'h0100)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .redir_valid (redir_valid),
      .redir_pc    (redir_pc),
      .i_halt      (i_halt),
      .bus         (bus.master)
   );

   always #5 clk = ~clk;

   // Memory model with a configurable number of wait states per read.
   always @(negedge clk) begin
      if (bus.mem_req) begin
         if (wcnt >= wait_states) begin
            mem_ack_r   = 1'b1;
            mem_rdata_r = mem[bus.mem_addr];
            wcnt        = 0;
         end else begin
            mem_ack_r   = 1'b0;
            mem_rdata_r = 8'hEE;
            wcnt        = wcnt + 1;
         end
      end else begin
         mem_ack_r = 1'b0;
         wcnt      = 0;
      end
   end

   always @(posedge clk) begin
      cyc = cyc + 1;
      if (rst_n) begin
         if (bus.mem_req && bus.mem_ack) acklog.push_back(bus.mem_addr);
         if (bus.ir_valid && bus.ir_ready && !redir_valid)
            conslog.push_back('{data: bus.instr, pc: bus.instr_pc, cb: bus.o_is_instr16, cyc: cyc});
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic pulse_redirect(input logic [15:0] pc);
      redir_valid = 1'b1;
      redir_pc    = pc;
      tick();
      redir_valid = 1'b0;
   endtask

   task automatic wait_cons(input int n, input int bound, input string name);
      int k = 0;
      while (conslog.size() < n && k < bound) begin
         tick();
         k++;
      end
      check(name, 32'(conslog.size() >= n), 32'd1);
   endtask

   task automatic wait_acks(input int n, input int bound, input string name);
      int k = 0;
      while (acklog.size() < n && k < bound) begin
         tick();
         k++;
      end
      check(name, 32'(acklog.size() >= n), 32'd1);
   endtask

   task automatic wait_idle(input int bound, input string name);
      int k = 0;
      while (bus.mem_req && k < bound) begin
         tick();
         k++;
      end
      check(name, 32'(bus.mem_req), 32'd0);
   endtask

   function automatic cons_t cons_at(input int i);
      cons_t c = '{data: 8'hEE, pc: 16'hDEAD, cb: 1'bx, cyc: -1};
      if (i < conslog.size()) c = conslog[i];
      return c;
   endfunction

   function automatic logic [15:0] ack_at(input int i);
      if (i < acklog.size()) return acklog[i];
      return 16'hDEAD;
   endfunction

   task automatic clear_logs();
      acklog.delete();
      conslog.delete();
   endtask

   initial begin
      for (int a = 0; a < 65536; a++) mem[a] = 8'h00;

      // Reset stream: 00,3E,42 then the CB-prefix sequence CB,11,CB,CB.
      tbl[0] = '{pc: 16'h0100, data: 8'h00, exp_cb: 1'b0};
      tbl[1] = '{pc: 16'h0101, data: 8'h3E, exp_cb: 1'b0};
      tbl[2] = '{pc: 16'h0102, data: 8'h42, exp_cb: 1'b0};
      tbl[3] = '{pc: 16'h0103, data: 8'hCB, exp_cb: 1'b0};
      tbl[4] = '{pc: 16'h0104, data: 8'h11, exp_cb: 1'b1};
      tbl[5] = '{pc: 16'h0105, data: 8'hCB, exp_cb: 1'b0};
      tbl[6] = '{pc: 16'h0106, data: 8'hCB, exp_cb: 1'b1};
      for (int i = 0; i < 7; i++) mem[tbl[i].pc] = tbl[i].data;

      mem[16'h2000] = 8'hAA;
      mem[16'h2001] = 8'hBB;
      mem[16'h2002] = 8'h77;
      mem[16'h3000] = 8'h5A;
      mem[16'h0038] = 8'h21;
      mem[16'hFFFF] = 8'hE5;
      mem[16'h0000] = 8'h76;
      mem[16'h4000] = 8'h3C;
      mem[16'h4001] = 8'h9D;

      ir_ready = 1'b1;
      repeat (3) tick();
      check("rst_mem_req",  32'(bus.mem_req),      32'd0);
      check("rst_mem_addr", 32'(bus.mem_addr),     32'h0100);
      check("rst_ir_valid", 32'(bus.ir_valid),     32'd0);
      check("rst_instr",    32'(bus.instr),        32'h00);
      check("rst_instr_pc", 32'(bus.instr_pc),     32'h0100);
      check("rst_cb",       32'(bus.o_is_instr16), 32'd0);

      // Zero-wait streaming, table-driven.
      rst_n = 1'b1;
      wait_cons(7, 40, "stream_timeout");
      ir_ready = 1'b0;
      for (int i = 0; i < 7; i++) begin
         check($sformatf("stream_instr%0d", i), 32'(cons_at(i).data), 32'(tbl[i].data));
         check($sformatf("stream_pc%0d", i),    32'(cons_at(i).pc),   32'(tbl[i].pc));
         check($sformatf("stream_cb%0d", i),    32'(cons_at(i).cb),   32'(tbl[i].exp_cb));
         check($sformatf("stream_addr%0d", i),  32'(ack_at(i)),       32'(tbl[i].pc));
         check($sformatf("stream_cyc%0d", i),   32'(cons_at(i).cyc - cons_at(0).cyc), 32'(i));
      end

      // Backpressure: two acks fill the queue, then requests stop.
      wait_idle(20, "bp_idle_timeout");
      clear_logs();
      pulse_redirect(16'h2000);
      check("bp_ir_valid_after_redir", 32'(bus.ir_valid), 32'd0);
      check("bp_first_addr",           32'(bus.mem_addr), 32'h2000);
      repeat (8) tick();
      check("bp_ack_count", 32'(acklog.size()), 32'd2);
      check("bp_mem_req",   32'(bus.mem_req),   32'd0);
      check("bp_instr",     32'(bus.instr),     32'hAA);
      ir_ready = 1'b1;
      wait_cons(2, 10, "bp_cons_timeout");
      ir_ready = 1'b0;
      check("bp_cons0_data", 32'(cons_at(0).data), 32'hAA);
      check("bp_cons0_pc",   32'(cons_at(0).pc),   32'h2000);
      check("bp_cons1_data", 32'(cons_at(1).data), 32'hBB);
      check("bp_cons1_pc",   32'(cons_at(1).pc),   32'h2001);
      wait_acks(3, 10, "bp_resume_timeout");
      check("bp_resume_addr", 32'(ack_at(2)), 32'h2002);

      // Redirect during a 3-wait-state read: address holds, byte dropped.
      wait_states = 3;
      wait_idle(40, "drain_idle_timeout");
      clear_logs();
      pulse_redirect(16'h3000);
      check("drain_req_start",  32'(bus.mem_req),  32'd1);
      check("drain_addr_start", 32'(bus.mem_addr), 32'h3000);
      tick();
      pulse_redirect(16'h0038);
      check("drain_addr_hold1", 32'(bus.mem_addr), 32'h3000);
      check("drain_req_hold",   32'(bus.mem_req),  32'd1);
      check("drain_ir_valid1",  32'(bus.ir_valid), 32'd0);
      tick();
      check("drain_addr_hold2", 32'(bus.mem_addr), 32'h3000);
      tick();
      check("drain_new_addr",   32'(bus.mem_addr), 32'h0038);
      check("drain_ir_valid2",  32'(bus.ir_valid), 32'd0);
      ir_ready = 1'b1;
      wait_cons(1, 30, "drain_cons_timeout");
      ir_ready = 1'b0;
      check("drain_cons_pc",   32'(cons_at(0).pc),   32'h0038);
      check("drain_cons_data", 32'(cons_at(0).data), 32'h21);
      check("drain_ack0",      32'(ack_at(0)),       32'h3000);
      check("drain_ack1",      32'(ack_at(1)),       32'h0038);

      // PC wrap from FFFF to 0000.
      wait_states = 0;
      wait_idle(40, "wrap_idle_timeout");
      clear_logs();
      pulse_redirect(16'hFFFF);
      repeat (5) tick();
      check("wrap_ack0",     32'(ack_at(0)),       32'hFFFF);
      check("wrap_ack1",     32'(ack_at(1)),       32'h0000);
      check("wrap_head_pc",  32'(bus.instr_pc),    32'hFFFF);
      ir_ready = 1'b1;
      wait_cons(2, 10, "wrap_cons_timeout");
      ir_ready = 1'b0;
      check("wrap_cons0_data", 32'(cons_at(0).data), 32'hE5);
      check("wrap_cons1_pc",   32'(cons_at(1).pc),   32'h0000);
      check("wrap_cons1_data", 32'(cons_at(1).data), 32'h76);

      // Halt raised with a read outstanding.
      wait_states = 3;
      wait_idle(40, "halt_idle_timeout");
      clear_logs();
      pulse_redirect(16'h4000);
      check("halt_req_outstanding", 32'(bus.mem_req), 32'd1);
      i_halt = 1'b1;
      wait_acks(1, 10, "halt_ack_timeout");
      repeat (6) tick();
      check("halt_mem_req",   32'(bus.mem_req),   32'd0);
      check("halt_ack_count", 32'(acklog.size()), 32'd1);
      check("halt_ir_valid",  32'(bus.ir_valid),  32'd1);
      check("halt_instr",     32'(bus.instr),     32'h3C);
      check("halt_instr_pc",  32'(bus.instr_pc),  32'h4000);
      ir_ready = 1'b1;
      wait_cons(1, 5, "halt_cons_timeout");
      ir_ready = 1'b0;
      check("halt_cons_pc", 32'(cons_at(0).pc), 32'h4000);
      repeat (4) tick();
      check("halt_still_no_req", 32'(bus.mem_req),   32'd0);
      check("halt_still_acks",   32'(acklog.size()), 32'd1);
      i_halt = 1'b0;
      wait_acks(2, 20, "halt_resume_timeout");
      check("halt_resume_addr", 32'(ack_at(1)), 32'h4001);

      // Asynchronous reset in the middle of a read.
      check("arst_req_before", 32'(bus.mem_req), 32'd1);
      rst_n = 1'b0;
      #1;
      check("arst_mem_req",  32'(bus.mem_req),  32'd0);
      check("arst_mem_addr", 32'(bus.mem_addr), 32'h0100);
      check("arst_ir_valid", 32'(bus.ir_valid), 32'd0);
      check("arst_instr_pc", 32'(bus.instr_pc), 32'h0100);
      check("arst_instr",    32'(bus.instr),    32'h00);
      repeat (2) tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
